code_entry_ctrl: RTL and testbench
==================================

// Module: code_entry_ctrl
// PURPOSE
//  Sequencer for the lab's code-lock datapath. Collects decimal digits from the
//  switches one per enter pulse, compares the complete entry against a fixed code,
//  and drives the done/incorrect pair that selects the status seven-segment text.
//  Holds each verdict for a programmable time, then counts failed attempts and
//  imposes a lockout. Sits between the button debouncers and the status/digit displays.
// PARAMETERS
//  DIGITS       4               number of digits per attempt (1..6)
//  CODE         24'h001234      secret code, 4 bits per BCD digit, LS digit = last entered
//  MAX_TRIES    3               consecutive failures that trigger lockout (>=1)
//  SHOW_CYCLES  50_000_000      clocks the verdict is held (1 s at 50 MHz); >=1
//  LOCK_CYCLES  250_000_000     clocks of lockout after MAX_TRIES failures; >=1
// PORTS
//  clk          in   1          system clock, all state on rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  digit_in     in   4          BCD digit from switches
//  enter        in   1          one-cycle pulse (already debounced/edge-detected)
//  clear        in   1          one-cycle pulse, discards partial entry
//  entry        out  4*DIGITS   digits entered so far, LS nibble = most recent
//  count        out  3          number of digits entered in current attempt
//  done         out  1          verdict valid (status display enable)
//  incorrect    out  1          verdict is failure; meaningful only while done=1
//  locked       out  1          lockout active
//  tries_left   out  2          MAX_TRIES minus consecutive failures
// BEHAVIOUR
//  Reset (async assert, sync release): state=ENTRY, entry=0, count=0, done=0,
//   incorrect=0, locked=0, tries_left=MAX_TRIES, timer=0.
//  States: ENTRY, CHECK, SHOW_OK, SHOW_BAD, LOCKOUT.
//  ENTRY: enter with digit_in<=9 shifts digit into entry (<<4), count++.
//   enter with digit_in>9 ignored (no state change). clear: entry=0, count=0.
//   clear and enter in same cycle: clear wins, digit discarded.
//   Enter that makes count==DIGITS -> CHECK next cycle.
//  CHECK (1 cycle): entry==CODE[4*DIGITS-1:0] -> SHOW_OK, tries_left=MAX_TRIES;
//   else failures+1; if failures==MAX_TRIES -> LOCKOUT, tries_left=0;
//   else SHOW_BAD, tries_left--. Timer loaded with SHOW_CYCLES-1 / LOCK_CYCLES-1.
//  Latency: final enter at edge t -> CHECK at t+1 -> done=1 from edge t+2.
//  SHOW_OK: done=1, incorrect=0 for exactly SHOW_CYCLES clocks.
//  SHOW_BAD: done=1, incorrect=1 for exactly SHOW_CYCLES clocks.
//  LOCKOUT: done=1, incorrect=1, locked=1 for exactly LOCK_CYCLES clocks;
//   on exit tries_left=MAX_TRIES.
//  Leaving any SHOW/LOCKOUT state -> ENTRY with entry=0, count=0, done=0.
//  enter/clear outside ENTRY are ignored (not queued).
//  Outputs registered; no combinational path from inputs to outputs.
//  rst_n low in any state (incl. mid-verdict or lockout) restores reset values
//   immediately; lockout is not persistent across reset.
//  Timer width = $clog2(max(SHOW_CYCLES,LOCK_CYCLES)); no wrap: stops at 0.
// STRUCTURE
//  Shared include code_lock_defs.vh: state encodings (3-bit localparams),
//   BCD_MAX=9, DIGIT_W=4; also used by the display decoders.
//  One sub-module: hold_timer (load value, load strobe, down-count, expired
//   flag), instantiated once and reused for SHOW and LOCKOUT durations.
//  FSM, entry shift register and failure counter live in code_entry_ctrl.
// TESTING (CODE=24'h001234, DIGITS=4, MAX_TRIES=3, SHOW_CYCLES=8, LOCK_CYCLES=20)
//  1) enter 1,2,3,4 -> count 1..4, CHECK, then done=1 incorrect=0 for 8 clks,
//     starting 2 clks after 4th enter; then count=0, entry=0.
//  2) enter 1,2,3,5 -> done=1 incorrect=1 for 8 clks, tries_left 3->2.
//  3) three wrong codes -> 3rd gives locked=1 done=1 incorrect=1 for 20 clks,
//     enters during lockout ignored; after exit tries_left=3.
//  4) enter 1,2, clear, enter 1,2,3,4 -> success; digit_in=4'hA ignored; clear+enter
//     same cycle -> count unchanged at 0.
//  5) rst_n low mid-SHOW_BAD and mid-LOCKOUT -> all outputs reset async same cycle.
//  6) wrong, wrong, correct, wrong -> tries_left 2,1,3,2; no lockout.

Source files
------------

// File: rtl/code_entry_ctrl_pkg.sv
// Shared types and constants for the code-lock entry sequencer.
// State encodings are 3-bit so the display decoders can match them directly.
package code_entry_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY    = 3'd0,
    ST_CHECK    = 3'd1,
    ST_SHOW_OK  = 3'd2,
    ST_SHOW_BAD = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_t;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/code_entry_ctrl_if.sv
// Bundle between the button/switch front end and the code-entry sequencer.
interface code_entry_ctrl_if #(
  parameter int DIGITS = 4
);
  import code_entry_ctrl_pkg::*;

  // enter/clear are single-cycle strobes with no ready: a strobe is consumed only
  // while the sequencer is collecting digits and is dropped otherwise. done acts
  // as the verdict valid; incorrect/locked/tries_left qualify it while done=1.
  logic [DIGIT_W-1:0]        digit_in;
  logic                      enter;
  logic                      clear;
  logic [DIGIT_W*DIGITS-1:0] entry;
  logic [2:0]                count;
  logic                      done;
  logic                      incorrect;
  logic                      locked;
  logic [1:0]                tries_left;

  modport master (
    output digit_in, enter, clear,
    input  entry, count, done, incorrect, locked, tries_left
  );

  modport slave (
    input  digit_in, enter, clear,
    output entry, count, done, incorrect, locked, tries_left
  );

endinterface

// File: rtl/code_entry_ctrl_hold_timer.sv
// Loadable down-counter that stops at zero; shared by the verdict and lockout holds.
module hold_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_run,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_run && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/code_entry_ctrl.sv
// Code-lock sequencer: collects BCD digits, checks them against CODE, holds the
// verdict for SHOW_CYCLES and imposes a LOCK_CYCLES lockout after MAX_TRIES failures.
module code_entry_ctrl
  import code_entry_ctrl_pkg::*;
#(
  parameter int          DIGITS      = 4,
  parameter logic [23:0] CODE        = 24'h001234,
  parameter int          MAX_TRIES   = 3,
  parameter int          SHOW_CYCLES = 50_000_000,
  parameter int          LOCK_CYCLES = 250_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  code_entry_ctrl_if.slave    bus,
  output state_t              o_state
);

  localparam int EW      = DIGIT_W * DIGITS;
  localparam int MAX_CYC = max_int(SHOW_CYCLES, LOCK_CYCLES);
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int FW      = $clog2(MAX_TRIES + 1);

  localparam logic [EW-1:0] CODE_SEL   = CODE[EW-1:0];
  localparam logic [TW-1:0] SHOW_LD    = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LD    = TW'(LOCK_CYCLES - 1);
  localparam logic [1:0]    TRIES_INIT = 2'(MAX_TRIES);
  localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_TRIES);

  state_t          r_state;
  logic [EW-1:0]   r_entry;
  logic [2:0]      r_count;
  logic            r_done;
  logic            r_incorrect;
  logic            r_locked;
  logic [1:0]      r_tries;
  logic [FW-1:0]   r_fails;

  logic            w_match;
  logic [FW-1:0]   w_fails_inc;
  logic            w_lock;
  logic [2:0]      w_count_inc;
  logic            w_digit_ok;
  logic            w_tmr_load;
  logic [TW-1:0]   w_tmr_val;
  logic            w_tmr_run;
  logic            w_tmr_expired;

  assign w_match     = (r_entry == CODE_SEL);
  assign w_fails_inc = r_fails + 1'b1;
  assign w_lock      = !w_match && (w_fails_inc == FAIL_LIMIT);
  assign w_count_inc = r_count + 3'd1;
  assign w_digit_ok  = (bus.digit_in <= BCD_MAX);

  // The timer is loaded during CHECK so its first held cycle already shows LD-1.
  assign w_tmr_load = (r_state == ST_CHECK);
  assign w_tmr_val  = w_lock ? LOCK_LD : SHOW_LD;
  assign w_tmr_run  = (r_state == ST_SHOW_OK) || (r_state == ST_SHOW_BAD) ||
                      (r_state == ST_LOCKOUT);

  hold_timer #(.W(TW)) u_hold_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_run      (w_tmr_run),
    .o_expired  (w_tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ENTRY;
      r_entry     <= '0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_incorrect <= 1'b0;
      r_locked    <= 1'b0;
      r_tries     <= TRIES_INIT;
      r_fails     <= '0;
    end else begin
      case (r_state)
        ST_ENTRY: begin
          if (bus.clear) begin
            r_entry <= '0;
            r_count <= '0;
          end else if (bus.enter && w_digit_ok) begin
            r_entry <= (r_entry << DIGIT_W) | EW'(bus.digit_in);
            r_count <= w_count_inc;
            if (w_count_inc == 3'(DIGITS)) begin
              r_state <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          r_done <= 1'b1;
          if (w_match) begin
            r_state     <= ST_SHOW_OK;
            r_incorrect <= 1'b0;
            r_tries     <= TRIES_INIT;
            r_fails     <= '0;
          end else if (w_lock) begin
            r_state     <= ST_LOCKOUT;
            r_incorrect <= 1'b1;
            r_locked    <= 1'b1;
            r_tries     <= 2'd0;
            r_fails     <= '0;
          end else begin
            r_state     <= ST_SHOW_BAD;
            r_incorrect <= 1'b1;
            r_tries     <= r_tries - 2'd1;
            r_fails     <= w_fails_inc;
          end
        end

        ST_SHOW_OK, ST_SHOW_BAD: begin
          if (w_tmr_expired) begin
            r_state     <= ST_ENTRY;
            r_entry     <= '0;
            r_count     <= '0;
            r_done      <= 1'b0;
            r_incorrect <= 1'b0;
          end
        end

        ST_LOCKOUT: begin
          if (w_tmr_expired) begin
            r_state     <= ST_ENTRY;
            r_entry     <= '0;
            r_count     <= '0;
            r_done      <= 1'b0;
            r_incorrect <= 1'b0;
            r_locked    <= 1'b0;
            r_tries     <= TRIES_INIT;
          end
        end

        default: r_state <= ST_ENTRY;
      endcase
    end
  end

  assign bus.entry      = r_entry;
  assign bus.count      = r_count;
  assign bus.done       = r_done;
  assign bus.incorrect  = r_incorrect;
  assign bus.locked     = r_locked;
  assign bus.tries_left = r_tries;
  assign o_state        = r_state;

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Bench for code_entry_ctrl: directed digit sequences; every verdict window is
// matched against an expected record queued by the driver.
module tb_code_entry_ctrl;
  import code_entry_ctrl_pkg::*;

  localparam int VW = 28;

  logic   clk;
  logic   rst_n;
  state_t st;
  int     cyc = 0;

  code_entry_ctrl_if #(.DIGITS(4)) bus ();

  code_entry_ctrl #(
    .DIGITS      (4),
    .CODE        (24'h001234),
    .MAX_TRIES   (3),
    .SHOW_CYCLES (8),
    .LOCK_CYCLES (20)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_state (st)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  logic [VW-1:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int n_pushed = 0;
  int n_popped = 0;
  int last_start;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // record = {incorrect, locked, tries[1:0], len[7:0], start[15:0]}
  task automatic push_verdict(input logic inc, input logic lck, input logic [1:0] tries,
                              input int len);
    logic [15:0] s;
    logic [7:0]  l;
    s = 16'(last_start + 2);
    l = 8'(len);
    exp_q.push_back({inc, lck, tries, l, s});
    n_pushed++;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic        in_v;
    logic        v_inc, v_lck, v_stable;
    logic [1:0]  v_tries;
    int          v_len, v_start;
    logic [VW-1:0] e;
    in_v = 1'b0;
    v_inc = 1'b0; v_lck = 1'b0; v_stable = 1'b1; v_tries = 2'd0; v_len = 0; v_start = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_v = 1'b0;
      end else if (bus.done) begin
        if (!in_v) begin
          in_v     = 1'b1;
          v_start  = cyc;
          v_inc    = bus.incorrect;
          v_lck    = bus.locked;
          v_tries  = bus.tries_left;
          v_len    = 1;
          v_stable = 1'b1;
        end else begin
          v_len++;
          if (bus.incorrect != v_inc || bus.locked != v_lck || bus.tries_left != v_tries)
            v_stable = 1'b0;
        end
      end else if (in_v) begin
        in_v = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL verdict_unexpected: got verdict at cycle %0d expected none", v_start);
        end else begin
          e = exp_q.pop_front();
          check("v_incorrect", int'(v_inc), int'(e[27]));
          check("v_locked",    int'(v_lck), int'(e[26]));
          check("v_tries",     int'(v_tries), int'(e[25:24]));
          check("v_len",       v_len, int'(e[23:16]));
          check("v_start",     v_start & 16'hFFFF, int'(e[15:0]));
          check("v_stable",    int'(v_stable), 1);
        end
        n_popped++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press(input logic [3:0] d, input logic clr);
    last_start   = cyc;
    bus.digit_in = d;
    bus.enter    = 1'b1;
    bus.clear    = clr;
    @(negedge clk);
    bus.enter    = 1'b0;
    bus.clear    = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) press(code[i*4 +: 4], 1'b0);
  endtask

  task automatic wait_verdicts();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_popped == n_pushed) break;
    end
    if (n_popped != n_pushed) begin
      n_checks++;
      n_err++;
      $display("FAIL verdict_timeout: got %0d verdicts expected %0d", n_popped, n_pushed);
      n_popped = n_pushed;
      exp_q.delete();
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_count"},     int'(bus.count), 0);
    check({tag, "_entry"},     int'(bus.entry), 0);
    check({tag, "_done"},      int'(bus.done), 0);
    check({tag, "_incorrect"}, int'(bus.incorrect), 0);
    check({tag, "_locked"},    int'(bus.locked), 0);
    check({tag, "_tries"},     int'(bus.tries_left), 3);
    check({tag, "_state"},     int'(st), int'(ST_ENTRY));
  endtask

  task automatic mid_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle(tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.digit_in = 4'd0;
    bus.enter = 1'b0;
    bus.clear = 1'b0;
    last_start = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset");

    // correct code, digit-by-digit progress
    press(4'd1, 1'b0); check("t1_count1", int'(bus.count), 1); check("t1_entry1", int'(bus.entry), 'h1);
    press(4'd2, 1'b0); check("t1_count2", int'(bus.count), 2); check("t1_entry2", int'(bus.entry), 'h12);
    press(4'd3, 1'b0); check("t1_count3", int'(bus.count), 3); check("t1_entry3", int'(bus.entry), 'h123);
    press(4'd4, 1'b0); check("t1_count4", int'(bus.count), 4); check("t1_entry4", int'(bus.entry), 'h1234);
    push_verdict(1'b0, 1'b0, 2'd3, 8);
    wait_verdicts();
    check_idle("t1_after");

    // wrong code then wrong, correct, wrong: tries 2,1,3,2
    enter_code(16'h1235); push_verdict(1'b1, 1'b0, 2'd2, 8); wait_verdicts();
    enter_code(16'h1111); push_verdict(1'b1, 1'b0, 2'd1, 8); wait_verdicts();
    enter_code(16'h1234); push_verdict(1'b0, 1'b0, 2'd3, 8); wait_verdicts();
    enter_code(16'h4321); push_verdict(1'b1, 1'b0, 2'd2, 8); wait_verdicts();
    check("t6_tries", int'(bus.tries_left), 2);
    check("t6_locked", int'(bus.locked), 0);

    // three consecutive failures -> lockout, enters ignored during it
    enter_code(16'h1234); push_verdict(1'b0, 1'b0, 2'd3, 8); wait_verdicts();
    enter_code(16'h9999); push_verdict(1'b1, 1'b0, 2'd2, 8); wait_verdicts();
    enter_code(16'h0000); push_verdict(1'b1, 1'b0, 2'd1, 8); wait_verdicts();
    enter_code(16'h5678); push_verdict(1'b1, 1'b1, 2'd0, 20);
    repeat (3) @(negedge clk);
    press(4'd1, 1'b0);
    press(4'd2, 1'b1);
    check("t3_lock_count", int'(bus.count), 4);
    check("t3_lock_entry", int'(bus.entry), 'h5678);
    check("t3_locked", int'(bus.locked), 1);
    wait_verdicts();
    check_idle("t3_after");

    // clear, invalid digit, clear+enter collision
    press(4'd1, 1'b0);
    press(4'd2, 1'b0);
    do_clear();
    check("t4_clear_count", int'(bus.count), 0);
    check("t4_clear_entry", int'(bus.entry), 0);
    press(4'hA, 1'b0);
    check("t4_bad_digit_count", int'(bus.count), 0);
    press(4'd5, 1'b1);
    check("t4_collide_count", int'(bus.count), 0);
    check("t4_collide_entry", int'(bus.entry), 0);
    enter_code(16'h1234); push_verdict(1'b0, 1'b0, 2'd3, 8); wait_verdicts();

    // async reset mid-SHOW_BAD and mid-LOCKOUT
    enter_code(16'h9876);
    repeat (4) @(negedge clk);
    check("t5_in_bad", int'(st), int'(ST_SHOW_BAD));
    mid_reset("t5_bad_rst");
    enter_code(16'h1000); push_verdict(1'b1, 1'b0, 2'd2, 8); wait_verdicts();
    enter_code(16'h2000); push_verdict(1'b1, 1'b0, 2'd1, 8); wait_verdicts();
    enter_code(16'h3000);
    repeat (8) @(negedge clk);
    check("t5_in_lock", int'(st), int'(ST_LOCKOUT));
    mid_reset("t5_lock_rst");

    repeat (12) @(negedge clk);
    check("end_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
